// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD command sequencer and its FIFO.
package lcd_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD, DRAIN} lcd_seq_state_t;

    typedef logic [8:0] lcd_entry_t;

    localparam int LCD_SEND_BIT        = 9;
    localparam int LCD_RS_BIT          = 8;
    localparam int LCD_DRV_SEND_CYCLES = 2500;

endpackage

// File: rtl/lcd_fifo.sv
// Synchronous FIFO of {rs, data} entries with full flush and keep-head flush.
module lcd_fifo
    import lcd_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       push,
    input  lcd_entry_t                 push_data,
    input  logic                       pop,
    input  logic                       flush,
    input  logic                       flush_keep_head,
    output lcd_entry_t                 head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    lcd_entry_t         mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr, wr_ptr, rd_ptr_n, wr_ptr_n;
    logic [CNT_W-1:0]   count_n;
    logic               push_ok, pop_ok, has_head;

    assign has_head = (count != '0);
    assign push_ok  = push && !full && !flush && !flush_keep_head;
    assign pop_ok   = pop && has_head && !flush;
    assign head     = mem[rd_ptr];

    always_comb begin
        rd_ptr_n = rd_ptr;
        wr_ptr_n = wr_ptr;
        count_n  = count;
        if (flush) begin
            wr_ptr_n = rd_ptr;
            count_n  = '0;
        end else if (flush_keep_head) begin
            // Only the head survives; if it is popped this cycle nothing survives.
            rd_ptr_n = pop_ok ? rd_ptr + PTR_W'(1) : rd_ptr;
            wr_ptr_n = has_head ? rd_ptr + PTR_W'(1) : rd_ptr;
            count_n  = (has_head && !pop_ok) ? CNT_W'(1) : '0;
        end else begin
            if (push_ok) wr_ptr_n = wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr_n = rd_ptr + PTR_W'(1);
            count_n = count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            rd_ptr <= rd_ptr_n;
            wr_ptr <= wr_ptr_n;
            count  <= count_n;
            full   <= (count_n == CNT_W'(DEPTH));
            empty  <= (count_n == '0);
        end
    end

    always_ff @(posedge CLK) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// Queues {rs, data} writes and hands them one at a time to the LCD driver
// through its send-bit / lcd_ready handshake, with a watchdog per transaction.
module lcd_cmd_sequencer
    import lcd_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       wr_en,
    input  logic [8:0]                 wr_data,
    input  logic                       flush,
    input  logic                       clr_err,
    input  logic                       lcd_ready,
    output logic [9:0]                 lcd_instr,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       busy,
    output logic                       overflow,
    output logic                       timeout_err,
    output lcd_seq_state_t             dbg_state
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    lcd_seq_state_t  state;
    lcd_entry_t      head, head_q;
    logic [WD_W-1:0] wd;
    logic            flushed_q;
    logic            in_xfer, done_ok, wd_expire, pop, fifo_flush, keep_head;

    assign dbg_state  = state;
    assign in_xfer    = (state == HOLD) || (state == DRAIN);
    assign done_ok    = (state == DRAIN) && lcd_ready;
    assign wd_expire  = in_xfer && !done_ok && (wd == WD_W'(TIMEOUT - 1));
    // An entry flushed away during ISSUE is no longer in the FIFO, so its pop is suppressed.
    assign pop        = (done_ok || wd_expire) && !flushed_q;
    assign fifo_flush = flush && !in_xfer;
    assign keep_head  = flush && in_xfer;

    lcd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLK             (CLK),
        .RST             (RST),
        .push            (wr_en),
        .push_data       (wr_data),
        .pop             (pop),
        .flush           (fifo_flush),
        .flush_keep_head (keep_head),
        .head            (head),
        .count           (count),
        .full            (full),
        .empty           (empty)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state       <= IDLE;
            lcd_instr   <= '0;
            busy        <= 1'b0;
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
            wd          <= '0;
            head_q      <= '0;
            flushed_q   <= 1'b0;
        end else begin
            if (clr_err)                        overflow <= 1'b0;
            else if (wr_en && full && !flush)   overflow <= 1'b1;

            if (clr_err)        timeout_err <= 1'b0;
            else if (wd_expire) timeout_err <= 1'b1;

            case (state)
                IDLE: begin
                    flushed_q <= 1'b0;
                    if (!empty && lcd_ready && !flush) begin
                        state     <= ISSUE;
                        head_q    <= head;
                        lcd_instr <= {1'b1, head};
                        busy      <= 1'b1;
                    end else begin
                        lcd_instr <= {1'b0, head};
                        busy      <= 1'b0;
                    end
                end
                ISSUE: begin
                    state     <= HOLD;
                    wd        <= '0;
                    lcd_instr <= {1'b0, head_q};
                    if (flush) flushed_q <= 1'b1;
                end
                HOLD, DRAIN: begin
                    lcd_instr <= {1'b0, head_q};
                    if (done_ok || wd_expire) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        wd <= wd + WD_W'(1);
                        if (state == HOLD && !lcd_ready) state <= DRAIN;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Directed bench for lcd_cmd_sequencer: a driver model answers the send bit
// and checks every issued entry against a queue of expected entries.
module tb_lcd_cmd_sequencer;
    import lcd_pkg::*;

    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 4096;
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    logic             CLK = 1'b0;
    logic             RST;
    logic             wr_en, flush, clr_err, lcd_ready;
    logic [8:0]       wr_data;
    logic [9:0]       lcd_instr;
    logic             full, empty, busy, overflow, timeout_err;
    logic [CNT_W-1:0] count;
    lcd_seq_state_t   dbg_state;

    lcd_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .flush       (flush),
        .clr_err     (clr_err),
        .lcd_ready   (lcd_ready),
        .lcd_instr   (lcd_instr),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .busy        (busy),
        .overflow    (overflow),
        .timeout_err (timeout_err),
        .dbg_state   (dbg_state)
    );

    // Clock / reset
    always #5 CLK = ~CLK;

    // Scoreboard
    logic [8:0] exp_q[$];
    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Driver model and monitor: captures each send, holds lcd_ready low for
    // send_cycles, and checks the captured entry against the expected queue.
    int         send_cycles = LCD_DRV_SEND_CYCLES;
    bit         drv_stall   = 1'b0;
    bit         drv_busy    = 1'b0;
    int         drv_cnt     = 0;
    int         rx_cnt      = 0;
    int         unstable    = 0;
    int         extra_send  = 0;
    logic [8:0] cap;

    initial lcd_ready = 1'b1;

    always @(negedge CLK) begin
        if (!RST) begin
            drv_busy  = 1'b0;
            lcd_ready = 1'b1;
        end else if (drv_busy) begin
            if (dbg_state != IDLE) begin
                if (lcd_instr[8:0] !== cap) unstable++;
                if (lcd_instr[9])           extra_send++;
            end
            if (drv_cnt > 0) drv_cnt--;
            else if (!drv_stall) begin
                lcd_ready = 1'b1;
                drv_busy  = 1'b0;
                check("head_stable", unstable, 0);
                check("single_send", extra_send, 0);
            end
        end else if (lcd_instr[9]) begin
            cap        = lcd_instr[8:0];
            drv_busy   = 1'b1;
            drv_cnt    = send_cycles;
            lcd_ready  = 1'b0;
            unstable   = 0;
            extra_send = 0;
            rx_cnt++;
            if (exp_q.size() == 0) check("unexpected_send", {23'd0, cap}, 32'hFFFF_FFFF);
            else                   check("entry_order", {23'd0, cap}, {23'd0, exp_q.pop_front()});
        end
    end

    // Driver tasks
    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic push(input logic [8:0] d, input bit accepted);
        wr_en   = 1'b1;
        wr_data = d;
        if (accepted) exp_q.push_back(d);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_state(input lcd_seq_state_t s, input int max_cycles);
        int n = 0;
        while (dbg_state != s && n < max_cycles) begin
            tick();
            n++;
        end
        check("wait_state", 32'(dbg_state), 32'(s));
    endtask

    task automatic wait_drained(input int max_cycles);
        int n = 0;
        while (!(empty && !busy && !drv_busy && lcd_ready) && n < max_cycles) begin
            tick();
            n++;
        end
        check("drain_done", {31'd0, empty && !busy && !drv_busy}, 1);
    endtask

    initial begin
        int rx0;
        int n;

        RST = 1'b0; wr_en = 1'b1; wr_data = 9'h155; flush = 1'b0; clr_err = 1'b0;

        // Reset held with wr_en asserted
        repeat (3) tick();
        check("rst_count", 32'(count), 0);
        check("rst_instr", 32'(lcd_instr), 0);
        check("rst_full", 32'(full), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_timeout", 32'(timeout_err), 0);

        // Single send with a full-length driver SEND
        RST = 1'b1;
        push(9'h141, 1'b1);
        check("first_write_count", 32'(count), 1);
        n = 0;
        while (lcd_instr != 10'h341 && n < 10) begin tick(); n++; end
        check("issue_instr", 32'(lcd_instr), 32'h341);
        tick();
        check("hold_instr", 32'(lcd_instr), 32'h141);
        check("hold_state", 32'(dbg_state), 32'(HOLD));
        check("hold_count", 32'(count), 1);
        wait_drained(3000);
        check("single_count", 32'(count), 0);

        // Ordering and backpressure
        send_cycles = 30;
        rx0 = rx_cnt;
        for (int i = 0; i < DEPTH; i++) push(9'(8'h30 + i), 1'b1);
        check("full_at_depth", 32'(full), 1);
        check("overflow_before", 32'(overflow), 0);
        push(9'h1EE, 1'b0);
        check("overflow_set", 32'(overflow), 1);
        check("count_at_depth", 32'(count), DEPTH);
        wait_drained(DEPTH * 50);
        check("order_rx_count", rx_cnt - rx0, DEPTH);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        check("overflow_cleared", 32'(overflow), 0);

        // Flush during DRAIN of entry 0
        rx0 = rx_cnt;
        for (int i = 0; i < 5; i++) push(9'(9'h150 + i), 1'b1);
        wait_state(DRAIN, 20);
        flush = 1'b1; tick(); flush = 1'b0;
        exp_q.delete();
        check("flush_keep_head", 32'(count), 1);
        wait_drained(200);
        check("flush_empty", 32'(empty), 1);
        check("flush_busy", 32'(busy), 0);
        check("flush_rx_count", rx_cnt - rx0, 1);

        // Watchdog: driver never returns ready
        drv_stall = 1'b1;
        push(9'h0AB, 1'b1);
        wait_state(HOLD, 10);
        repeat (TIMEOUT - 1) tick();
        check("wd_not_yet", 32'(timeout_err), 0);
        tick();
        check("wd_expired", 32'(timeout_err), 1);
        check("wd_popped", 32'(count), 0);
        check("wd_idle", 32'(dbg_state), 32'(IDLE));
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        check("wd_cleared", 32'(timeout_err), 0);
        drv_stall = 1'b0;
        wait_drained(100);

        // Write and pop in the same cycle
        rx0 = rx_cnt;
        for (int i = 0; i < 4; i++) push(9'(9'h020 + i), 1'b1);
        n = 0;
        while (!(dbg_state == DRAIN && lcd_ready) && n < 200) begin tick(); n++; end
        check("pop_cycle_seen", {31'd0, dbg_state == DRAIN && lcd_ready}, 1);
        push(9'h024, 1'b1);
        check("push_pop_count", 32'(count), 4);
        wait_drained(400);
        check("push_pop_rx", rx_cnt - rx0, 5);

        // Reset during DRAIN abandons the transaction
        push(9'h1C0, 1'b1);
        push(9'h1C1, 1'b1);
        wait_state(DRAIN, 20);
        RST = 1'b0;
        tick();
        exp_q.delete();
        check("rst_drain_state", 32'(dbg_state), 32'(IDLE));
        check("rst_drain_instr", 32'(lcd_instr), 0);
        check("rst_drain_count", 32'(count), 0);
        RST = 1'b1;
        rx0 = rx_cnt;
        push(9'h1F0, 1'b1);
        wait_drained(200);
        check("post_rst_rx", rx_cnt - rx0, 1);
        check("exp_q_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
